rv32_alu: RTL and testbench

- RV32I integer ALU for the microcoded CPU core.
- Computes the arithmetic/logic result and the branch-compare flag for the operation selected by a 4-bit opcode {instr[30], funct3}.
- Operands are the register-file read value and the decoded second operand (register or immediate).
- Result and flag are registered: one clock of latency, asynchronous active-high reset.

---
 rtl/rv32_alu.sv | 73 +++++++
 tb/tb_rv32_alu.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rv32_alu.sv
// rtl/rv32_alu.sv - RV32I integer ALU with registered result and branch-compare flag
module rv32_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rts,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] alu_out,
  output logic             cmp_flag
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]   shamt;
  logic             lt_s;
  logic             lt_u;
  logic             eq;
  logic [WIDTH-1:0] result_d;
  logic             flag_d;

  // Shared comparator terms; only the low shift bits ever reach the shifters.
  always_comb begin
    shamt = operand_b[SHW-1:0];
    lt_s  = $signed(operand_a) < $signed(operand_b);
    lt_u  = operand_a < operand_b;
    eq    = operand_a == operand_b;
  end

  // Result select; alt-op bit only matters for ADD/SUB and SRL/SRA.
  always_comb begin
    result_d = '0;
    case (alu_op[2:0])
      3'b000:  result_d = alu_op[3] ? (operand_a - operand_b) : (operand_a + operand_b);
      3'b001:  result_d = operand_a << shamt;
      3'b010:  result_d = {{(WIDTH-1){1'b0}}, lt_s};
      3'b011:  result_d = {{(WIDTH-1){1'b0}}, lt_u};
      3'b100:  result_d = operand_a ^ operand_b;
      3'b101:  result_d = alu_op[3] ? WIDTH'($signed(operand_a) >>> shamt)
                                    : (operand_a >> shamt);
      3'b110:  result_d = operand_a | operand_b;
      default: result_d = operand_a & operand_b;
    endcase
  end

  // Branch condition from funct3 alone; bit3 may hold an immediate bit.
  always_comb begin
    flag_d = 1'b0;
    case (alu_op[2:0])
      3'b000:  flag_d = eq;
      3'b001:  flag_d = ~eq;
      3'b010:  flag_d = lt_s;
      3'b011:  flag_d = lt_u;
      3'b100:  flag_d = lt_s;
      3'b101:  flag_d = ~lt_s;
      3'b110:  flag_d = lt_u;
      default: flag_d = ~lt_u;
    endcase
  end

  // Output registers: the only state in the block.
  always_ff @(posedge clk or posedge rts) begin
    if (rts) begin
      alu_out  <= '0;
      cmp_flag <= 1'b0;
    end else begin
      alu_out  <= result_d;
      cmp_flag <= flag_d;
    end
  end

endmodule

// File: tb/tb_rv32_alu.sv
// tb/tb_rv32_alu.sv - self-checking bench for rv32_alu with directed and random operations
module tb_rv32_alu;

  logic        clk;
  logic        rts;
  logic [3:0]  alu_op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] alu_out;
  logic        cmp_flag;

  int passed;
  int total;

  rv32_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rts       (rts),
    .alu_op    (alu_op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .alu_out   (alu_out),
    .cmp_flag  (cmp_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result written from the instruction-set definitions.
  function automatic logic [31:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    int          sa;
    int          sb;
    int          s;
    logic [31:0] ones;
    logic [31:0] fill;
    sa   = a;
    sb   = b;
    s    = int'(b % 32);
    ones = 32'hFFFF_FFFF;
    fill = a[31] ? ~(ones >> s) : 32'h0;
    case (op[2:0])
      3'd0:    return op[3] ? 32'(a - b) : 32'(a + b);
      3'd1:    return 32'(a << s);
      3'd2:    return (sa < sb) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return op[3] ? ((a >> s) | fill) : (a >> s);
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic model_flag(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd2:    return sa < sb;
      3'd3:    return a < b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return a < b;
      default: return a >= b;
    endcase
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Present one operation between edges and sample just after the capturing edge.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    alu_op    = op;
    operand_a = a;
    operand_b = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] corners [6];
    passed    = 0;
    total     = 0;
    rts       = 1'b1;
    alu_op    = 4'b0000;
    operand_a = 32'd5;
    operand_b = 32'd3;
    corners[0] = 32'h0000_0000;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h8000_0000;
    corners[3] = 32'h7FFF_FFFF;
    corners[4] = 32'h0000_0001;
    corners[5] = 32'h0000_001F;

    repeat (2) @(posedge clk);
    #1;
    check32("reset_out", alu_out, 32'h0);
    check1("reset_flag", cmp_flag, 1'b0);

    @(negedge clk);
    rts = 1'b0;
    @(posedge clk);
    #1;
    check32("post_reset_add", alu_out, 32'd8);

    // Assert reset away from any edge: outputs must clear without a clock.
    #2;
    rts = 1'b1;
    #1;
    check32("async_reset_out", alu_out, 32'h0);
    check1("async_reset_flag", cmp_flag, 1'b0);
    @(negedge clk);
    rts = 1'b0;
    #1;
    check32("held_until_edge", alu_out, 32'h0);
    @(posedge clk);
    #1;
    check32("release_add", alu_out, 32'd8);

    do_op(4'b0000, 32'hFFFF_FFFF, 32'h1);
    check32("add_wrap", alu_out, 32'h0);
    do_op(4'b1000, 32'h0, 32'h1);
    check32("sub_wrap", alu_out, 32'hFFFF_FFFF);
    do_op(4'b0000, 32'h10, 32'hFFFF_FFFC);
    check32("add_neg", alu_out, 32'h0000_000C);

    do_op(4'b0001, 32'h1, 32'h25);
    check32("sll_5bit", alu_out, 32'h20);
    do_op(4'b0101, 32'h8000_0000, 32'h4);
    check32("srl", alu_out, 32'h0800_0000);
    do_op(4'b1101, 32'h8000_0000, 32'h4);
    check32("sra", alu_out, 32'hF800_0000);
    do_op(4'b1101, 32'h1234_5678, 32'h0);
    check32("sra_zero", alu_out, 32'h1234_5678);

    do_op(4'b0010, 32'hFFFF_FFFF, 32'h1);
    check32("slt", alu_out, 32'h1);
    do_op(4'b0011, 32'hFFFF_FFFF, 32'h1);
    check32("sltu", alu_out, 32'h0);
    do_op(4'b0100, 32'hFFFF_FFFF, 32'h1);
    check1("blt_flag", cmp_flag, 1'b1);
    do_op(4'b0110, 32'hFFFF_FFFF, 32'h1);
    check1("bltu_flag", cmp_flag, 1'b0);

    do_op(4'b1101, 32'h8000_0000, 32'h0);
    check1("bge_false", cmp_flag, 1'b0);
    check32("bge_sra", alu_out, 32'h8000_0000);
    do_op(4'b0000, 32'h1234, 32'h1234);
    check1("beq_flag", cmp_flag, 1'b1);
    do_op(4'b0001, 32'h1234, 32'h1234);
    check1("bne_flag", cmp_flag, 1'b0);
    do_op(4'b1111, 32'hFFFF_FFFF, 32'h0);
    check1("bgeu_flag", cmp_flag, 1'b1);
    check32("and_bit3", alu_out, 32'h0);

    do_op(4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00);
    check32("xor_b2b", alu_out, 32'h0FF0_0FF0);
    do_op(4'b1110, 32'hF0F0_F0F0, 32'hFF00_FF00);
    check32("or_b2b", alu_out, 32'hFFF0_FFF0);
    do_op(4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00);
    check32("and_b2b", alu_out, 32'hF000_F000);

    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      do_op(op, a, b);
      check32($sformatf("rand_out[%0d] op=%b a=%h b=%h", i, op, a, b), alu_out,
              model_result(op, a, b));
      check1($sformatf("rand_flag[%0d] op=%b a=%h b=%h", i, op, a, b), cmp_flag,
             model_flag(op[2:0], a, b));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
